seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clock cycles each digit is held active (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port value  input  16  four hex digits to display; value[3:0] is digit 0 (rightmost).
REQ-005 SHALL have port load  input  1  one-cycle strobe; capture value into the pending register.
REQ-006 SHALL have port hex  output  4  nibble of the active digit, fed directly to hex2seg.
REQ-007 SHALL have port dig  output  4  one-hot digit enable, active-high; dig[i] selects digit i.
REQ-008 SHALL have port blank  output  1  active digit is to be suppressed; downstream drives the segments off.
REQ-009 SHALL have port frame  output  1  one-cycle pulse marking the first cycle of digit 0 in each frame.

Function
REQ-010 SHALL hold a divider counter cnt counting 0..CLK_DIV-1 and a digit index idx counting 0..3.
REQ-011 SHALL, on the edge where cnt==CLK_DIV-1, reset cnt to 0 and advance idx by one; idx wraps 3->0.
REQ-012 SHALL otherwise increment cnt and hold idx.
REQ-013 SHALL register all outputs, so dig, hex and blank change only on the edge that advances idx.
REQ-014 SHALL keep each digit active for exactly CLK_DIV cycles; a full frame SHALL be 4*CLK_DIV cycles.
REQ-015 SHALL, when CLK_DIV==1, advance idx on every cycle.
REQ-016 SHALL drive dig with exactly one bit set at all times, including during and after reset.
REQ-017 SHALL drive hex equal to disp[4*idx+3:4*idx] for the active idx.
REQ-018 SHALL latch value into pending on any cycle with load=1; a later load SHALL overwrite an earlier one.
REQ-019 SHALL copy pending into the display register disp only on the wrap edge (idx 3->0), so no frame ever mixes old and new digits.
REQ-020 SHALL, when load=1 on the wrap-edge cycle itself, copy that cycle's value directly into disp, and digit 0 of the new frame SHALL show it.
REQ-021 SHALL assert frame for exactly the cycle after the wrap edge, then deassert it for the remaining 4*CLK_DIV-1 cycles.
REQ-022 SHALL ignore load while rst is asserted.

Reset
REQ-023 SHALL, while rst=1 and irrespective of clk, force cnt=0, idx=0, pending=0, disp=0.
REQ-024 SHALL, while rst=1, force outputs hex=0, dig=4'b0001, blank=0 and frame=0.
REQ-025 SHALL, on the first edge after rst is released, begin counting with digit 0 active and no frame pulse.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the frame immediately and discard any pending load.

Configuration
REQ-027 SHALL use macro SEG_SCAN_LZ_BLANK_EN to compile leading-zero blanking in or out.
REQ-028 SHALL, with the macro defined, assert blank for digit i (i>0) when nibbles i..3 of disp are all zero.
REQ-029 SHALL, with the macro defined, never blank digit 0, so disp=0 displays a single "0".
REQ-030 SHALL, without the macro, tie blank to 0 and contain no blanking logic.

Verification
REQ-031 SHALL cover: CLK_DIV=4, release rst -> dig=0001 for 4 cycles, then 0010, 0100, 1000, 0001; frame pulses every 16 cycles.
REQ-032 SHALL cover: load value=16'h1A2F mid-frame -> current frame unchanged; next frame hex = F,2,A,1 on digits 0..3.
REQ-033 SHALL cover: load value=16'h1234 on the wrap-edge cycle -> the immediately following digit 0 shows hex=4.
REQ-034 SHALL cover: with the macro defined, load value=16'h0050 -> blank=1 on digits 3,2 and blank=0 on digits 1,0; with value=16'h0000, only digit 0 is unblanked.
REQ-035 SHALL cover: assert rst during digit 2 -> dig=0001, hex=0 and frame=0 asynchronously, without waiting for a clk edge.
REQ-036 SHALL cover: CLK_DIV=1 -> dig rotates every cycle and frame pulses every 4 cycles.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for a four-digit hex display.
// Each digit is held active for CLK_DIV cycles, and digit 0 is the first
// digit of every frame. New values are staged in a pending register. They
// reach the display register only at the frame wrap, so a frame never shows
// a mix of old and new digits.
// Optional build macro SEG_SCAN_LZ_BLANK_EN compiles in leading-zero
// blanking. Digit 0 is never blanked.
module seg_scan #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  hex,
  output logic [3:0]  dig,
  output logic        blank,
  output logic        frame
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  hex_q, hex_d;
  logic [3:0]  dig_q, dig_d;
  logic        frame_q, frame_d;
  logic        adv, wrap;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic        blank_q, blank_d;

  // A digit is blank when it and every more-significant nibble are zero.
  // Digit 0 always shows, so an all-zero value displays a single "0".
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] i);
    logic r;
    case (i)
      2'd1:    r = (d[15:4] == 12'h000);
      2'd2:    r = (d[15:8] == 8'h00);
      2'd3:    r = (d[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  // Next-state logic: divider, digit index, load staging and output registers
  always_comb begin
    adv     = (cnt_q == DIV_LAST);
    wrap    = adv && (idx_q == 2'd3);
    cnt_d   = adv ? 16'd0 : cnt_q + 16'd1;
    idx_d   = adv ? idx_q + 2'd1 : idx_q;
    pend_d  = load ? value : pend_q;
    disp_d  = disp_q;
    dig_d   = dig_q;
    hex_d   = hex_q;
    frame_d = wrap;
`ifdef SEG_SCAN_LZ_BLANK_EN
    blank_d = blank_q;
`endif
    // A load on the wrap cycle itself bypasses pending and is shown at once.
    if (wrap) begin
      disp_d = load ? value : pend_q;
    end
    // Outputs move only when the index advances, and they track the new disp.
    if (adv) begin
      dig_d = 4'b0001 << idx_d;
      hex_d = disp_d[{idx_d, 2'b00} +: 4];
`ifdef SEG_SCAN_LZ_BLANK_EN
      blank_d = lz_blank(disp_d, idx_d);
`endif
    end
  end

  // State and registered outputs; reset is asynchronous and clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      pend_q  <= 16'd0;
      disp_q  <= 16'd0;
      hex_q   <= 4'h0;
      dig_q   <= 4'b0001;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      hex_q   <= hex_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Blank flag register, updated alongside dig and hex
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign hex   = hex_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule
